// File: rtl/cache_line_burst_adapter.sv
// cache_line_burst_adapter: splits 128-bit cache line transfers into BEATS-beat bursts on a narrow memory bus
module cache_line_burst_adapter #(
  parameter int BEATS = 4,
  parameter int BEAT_W = 128 / BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [15:0]       pmem_address,
  input  logic [127:0]      pmem_wdata,
  output logic [127:0]      pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [15:0]       burst_address,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [127:0] line;
  logic in_burst, last;
  assign in_burst = (state == RD_BURST) || (state == WR_BURST);
  assign last = burst_resp && (cnt == CW'(BEATS - 1));
  // Write beats come straight from the latched line so they hold through wait states
  assign burst_wdata = line[cnt*BEAT_W +: BEAT_W];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pmem_write ? WR_BURST : pmem_read ? RD_BURST : IDLE;
      RESP:    state_n = IDLE;
      default: state_n = last ? RESP : state;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      burst_address <= '0;
      pmem_rdata <= '0;
      pmem_resp <= 1'b0;
      burst_read <= 1'b0;
      burst_write <= 1'b0;
    end else begin
      state <= state_n;
      pmem_resp <= state_n == RESP;
      burst_read <= state_n == RD_BURST;
      burst_write <= state_n == WR_BURST;
      if (state == IDLE && (pmem_write || pmem_read)) begin
        cnt <= '0;
        burst_address <= {pmem_address[15:4], 4'b0};
        if (pmem_write) line <= pmem_wdata;
      end
      if (in_burst && burst_resp) cnt <= cnt + 1'b1;
      if (state == RD_BURST && burst_resp) pmem_rdata[cnt*BEAT_W +: BEAT_W] <= burst_rdata;
    end
  end
endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// tb_cache_line_burst_adapter: directed scoreboard bench with a behavioural burst memory responder
`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end
module tb_cache_line_burst_adapter;
  localparam int BEATS = 4;
  localparam int BW = 128 / BEATS;
  logic clk = 0, rst = 1, pmem_read = 0, pmem_write = 0;
  logic [15:0] pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic pmem_resp, burst_read, burst_write, burst_resp = 0;
  logic [15:0] burst_address;
  logic [BW-1:0] burst_wdata, burst_rdata = '0;
  int n_chk = 0, n_fail = 0, resp_cnt = 0, exp_resp = 0, beat = 0, waits = 0, wc = 0;
  logic saw_read = 0, prev_cmd = 0;
  logic [BW-1:0] rd_beats [BEATS];
  logic [BW-1:0] wq [$];
  logic [127:0] rq [$];
  logic [15:0] aq [$];

  cache_line_burst_adapter #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  // Memory model: 'waits' idle cycles before each accepted beat
  initial forever begin
    @(posedge clk);
    #1;
    if ((burst_read || burst_write) && !rst) begin
      if (wc < waits) begin
        burst_resp = 0;
        wc++;
      end else begin
        burst_resp = 1;
        burst_rdata = rd_beats[beat % BEATS];
        beat++;
        wc = 0;
      end
    end else begin
      burst_resp = 0;
      beat = 0;
      wc = 0;
    end
  end

  initial begin
    logic [BW-1:0] ew;
    logic [127:0] el;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      if (burst_read) saw_read = 1;
      if ((burst_read || burst_write) && !prev_cmd) begin
        `CHK("cmd_excl", burst_read & burst_write, 1'b0)
        if (aq.size() > 0) begin
          ea = aq.pop_front();
          `CHK("burst_addr", burst_address, ea)
        end else begin
          n_chk++; n_fail++;
          $error("FAIL burst_start: observed unexpected burst expected none");
        end
      end
      prev_cmd = burst_read || burst_write;
      if (burst_write) begin
        if (wq.size() == 0) begin
          n_chk++; n_fail++;
          $error("FAIL wbeat_extra: observed %0h expected no beat", burst_wdata);
        end else if (burst_resp) begin
          ew = wq.pop_front();
          `CHK("wbeat", burst_wdata, ew)
        end else begin
          ew = wq[0];
          `CHK("wbeat_hold", burst_wdata, ew)
        end
      end
      if (pmem_resp) begin
        resp_cnt++;
        if (rq.size() > 0) begin
          el = rq.pop_front();
          `CHK("rline", pmem_rdata, el)
        end
      end
    end
  end

  task automatic xfer(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [127:0] d, input logic [127:0] line_exp);
    int n = 0;
    int lat = BEATS * (waits + 1) + 2;
    if (wr) for (int k = 0; k < BEATS; k++) wq.push_back(d[k*BW +: BW]);
    else rq.push_back(line_exp);
    aq.push_back({a[15:4], 4'h0});
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_resp && n < 200);
    `CHK("latency", n, lat)
    exp_resp++;
    @(posedge clk);
    #1 pmem_read = 0; pmem_write = 0;
  endtask

  initial begin
    rd_beats = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    repeat (2) @(negedge clk);
    `CHK("rst_resp", pmem_resp, 1'b0)
    `CHK("rst_bread", burst_read, 1'b0)
    `CHK("rst_bwrite", burst_write, 1'b0)
    `CHK("rst_addr", burst_address, 16'h0)
    `CHK("rst_wdata", burst_wdata, 32'h0)
    `CHK("rst_rdata", pmem_rdata, 128'h0)
    rst = 0;
    @(posedge clk);
    #1;
    // zero-wait read
    xfer(1, 0, 16'h1234, '0, 128'h44444444_33333333_22222222_11111111);
    `CHK("rd_hold", pmem_rdata, 128'h44444444_33333333_22222222_11111111)
    // write with waits and inputs changed mid-burst
    waits = 2;
    fork
      begin
        repeat (3) @(posedge clk);
        #2 pmem_wdata = 128'h0; pmem_address = 16'hFFFF;
      end
    join_none
    xfer(0, 1, 16'h5678, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0);
    `CHK("wr_rdata_hold", pmem_rdata, 128'h44444444_33333333_22222222_11111111)
    `CHK("wq_drained", wq.size(), 0)
    // read and write together: write wins
    waits = 0;
    saw_read = 0;
    xfer(1, 1, 16'h00F0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, '0);
    `CHK("no_read_cmd", saw_read, 1'b0)
    // back-to-back write then read
    rd_beats = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    xfer(0, 1, 16'h0100, 128'h44443333_22221111_88887777_66665555, '0);
    xfer(1, 0, 16'h0200, '0, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    repeat (3) @(negedge clk);
    `CHK("resp_cnt", resp_cnt, exp_resp)
    // reset in the middle of a read burst
    @(posedge clk);
    #1;
    aq.push_back(16'h0440);
    pmem_read = 1; pmem_address = 16'h0447;
    begin
      int n = 0;
      while (beat < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      `CHK("mid_wait", n < 50, 1'b1)
    end
    @(posedge clk);
    #2 rst = 1;
    pmem_read = 0;
    #1;
    `CHK("rst_mid_bread", burst_read, 1'b0)
    `CHK("rst_mid_rdata", pmem_rdata, 128'h0)
    `CHK("rst_mid_resp", pmem_resp, 1'b0)
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    `CHK("rst_no_resp", resp_cnt, exp_resp)
    @(posedge clk);
    #1;
    rd_beats = '{32'h0F0F0F0F, 32'h1E1E1E1E, 32'h2D2D2D2D, 32'h3C3C3C3C};
    xfer(1, 0, 16'h0880, '0, 128'h3C3C3C3C_2D2D2D2D_1E1E1E1E_0F0F0F0F);
    repeat (4) @(negedge clk);
    `CHK("resp_final", resp_cnt, exp_resp)
    `CHK("aq_drained", aq.size(), 0)
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_line_burst_adapter.md
Name: cache_line_burst_adapter

Overview:
Sits directly downstream of the cache, between its physical-memory port and a narrow burst memory. Converts each single-cycle 128-bit line request (pmem_read/pmem_write) into a BEATS-beat burst on a BEAT_W-bit memory bus. Reads assemble the line before responding; writes serialize the latched line. A single pmem_resp pulse is returned to the cache per line transfer.

Parameters:
BEATS, 4, beats per 128-bit line; legal values 2, 4 or 8.
BEAT_W, 128/BEATS, burst data width in bits (derived; not overridden independently).

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
pmem_read  input  1  cache line-read request, held until pmem_resp
pmem_write  input  1  cache line-write request, held until pmem_resp
pmem_address  input  16  cache line address; bits [3:0] ignored
pmem_wdata  input  128  line to write, valid while pmem_write is high
pmem_rdata  output  128  assembled read line
pmem_resp  output  1  one-cycle completion pulse to the cache
burst_read  output  1  burst read command, held for the whole burst
burst_write  output  1  burst write command, held for the whole burst
burst_address  output  16  line base address, {pmem_address[15:4], 4'b0}, held for the whole burst
burst_wdata  output  BEAT_W  current write beat
burst_rdata  input  BEAT_W  current read beat
burst_resp  input  1  beat accepted (write) / beat valid (read), one per cycle max

Behaviour:
- Reset (async, immediate): state IDLE; beat counter 0. pmem_resp, burst_read and burst_write are 0. burst_address, burst_wdata and pmem_rdata are 0.
- States: IDLE, RD_BURST, WR_BURST, RESP.
- IDLE, request sampling:
  - If pmem_write: latch pmem_wdata and the line address, clear the counter, go to WR_BURST.
  - Else if pmem_read: latch the line address, clear the counter, go to RD_BURST.
  - If both are high, write wins.
- RD_BURST:
  - burst_read=1.
  - On each burst_resp, burst_rdata is stored into pmem_rdata[k*BEAT_W +: BEAT_W], k = counter (beat 0 is the LSBs), and the counter increments.
  - On the burst_resp with k=BEATS-1, go to RESP.
- WR_BURST:
  - burst_write=1 and burst_wdata = latched line[k*BEAT_W +: BEAT_W].
  - On burst_resp the counter increments and burst_wdata advances the next cycle.
  - On the burst_resp with k=BEATS-1, go to RESP.
- RESP: pmem_resp=1 for exactly one cycle, then IDLE. burst_read and burst_write are 0 in RESP.
- Command framing:
  - burst_read and burst_write are registered outputs. They rise the cycle after the request is sampled and fall the cycle after the final burst_resp.
  - burst_read and burst_write are never high together.
- Latency, with zero-wait memory (burst_resp high every cycle): request seen at edge 0; beats at edges 1..BEATS; pmem_resp high in the cycle after edge BEATS. Total BEATS+2 cycles from request to response.
- Wait states: cycles with burst_resp low hold the counter, the address and burst_wdata unchanged. There is no timeout.
- pmem_rdata:
  - Changes only on read beats and holds between transfers.
  - It is stable and complete throughout RESP.
  - It is not cleared at the start of a new read.
- Ignored inputs outside IDLE: pmem_address and pmem_wdata changes mid-burst have no effect (latched copies are used). pmem_read and pmem_write are ignored outside IDLE.
- Cache handshake: the cache drops its request on the edge that ends RESP. The adapter is back in IDLE the following cycle, so a request still high then is treated as a new transfer.
- Counter width is clog2(BEATS). The counter wraps to 0 on the final beat.
- Stray burst_resp in IDLE or RESP is ignored.
- Reset asserted mid-burst: all commands deassert immediately, no pmem_resp is issued, and the partial line is discarded (pmem_rdata returns to 0).

Test Plan:
- Read, zero-wait, BEATS=4: pmem_read at 0x1234, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> burst_address=0x1230; pmem_rdata=0x44444444_33333333_22222222_11111111; single pmem_resp 6 cycles after request.
- Write with waits: pmem_wdata=0xDDDD..._CCCC..._BBBB..._AAAA..., burst_resp low 2 cycles before each beat -> burst_wdata sequence 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD, each held through its waits; one pmem_resp.
- Simultaneous pmem_read and pmem_write at 0x00F0 -> write burst only; burst_read never asserted; one pmem_resp.
- Back-to-back: write at 0x0100 then read at 0x0200 immediately after pmem_resp -> two distinct bursts with correct addresses; no extra pmem_resp.
- Reset after beat 2 of a read -> burst_read=0 in the same cycle; pmem_rdata=0; no pmem_resp; a subsequent read completes normally.
- Address/data change mid-write: pmem_wdata altered after IDLE sample -> beats carry the originally latched line.
